bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
- Consumes the slow square wave from the board clock divider (`divided_clk`, nominally 1 Hz) on the 100 MHz domain.
- Counts its rising edges as a 4-digit BCD seconds counter (0000–9999) with run/clear controls.
- Drives the 4-digit multiplexed, active-low seven-segment display directly.
- Sits between the clock divider and the board display pins.

Parameters:
- SCAN_DIV, 99999: scan-prescaler terminal count. Display digit advances every SCAN_DIV+1 clk cycles (1 ms at 100 MHz). Legal range 1 … 2^20-1.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- tick_in  in  1  slow square wave from the clock divider; treated as asynchronous level
- run  in  1  switch level; 1 = count enabled; asynchronous
- clear  in  1  button level; 1 = hold count at zero; asynchronous
- bcd_out  out  16  {d3,d2,d1,d0}, 4 bits per digit, d0 least significant
- rollover  out  1  one-cycle pulse on 9999→0000 wrap
- seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- an  out  4  digit anodes, active-low one-hot, an[0] = d0

Behaviour:
- Reset: one clock, asynchronous active-high. While rst=1, all flops clear immediately:
  - synchronizers = 0, edge-history flop = 0
  - bcd_out = 16'h0000, rollover = 0
  - scan counter = 0, digit index = 0
  - an = 4'b1110, seg = 7'b1000000
- Reset mid-count discards the count; any partially detected edge is dropped.
- Input synchronization: tick_in, run and clear each pass through a 2-flop synchronizer. tick_s also feeds a history flop tick_d. Edge strobe: tick_rise = tick_s & ~tick_d.
- Latency: tick_in first sampled high at edge N → tick_rise high between edges N+1 and N+2 → bcd_out updated at edge N+2.
- Priority, per cycle:
  1. clear_s = 1 → bcd_out = 0000, rollover = 0, tick_rise ignored.
  2. Else run_s = 1 and tick_rise = 1 → increment.
  3. Else hold.
- Ticks arriving while run_s = 0 or clear_s = 1 are discarded, never queued. Exactly one increment per tick_in rising edge, regardless of tick_in high time.
- Increment (BCD ripple):
  - d0 += 1; if d0 was 9, d0 = 0 and carry into d1; same rule through d3.
  - 9999 → 0000 with rollover = 1 for exactly that cycle. rollover is registered alongside bcd_out, so both change on the same edge. Otherwise rollover = 0.
- Digits never hold values 10–15.
- Display scan:
  - Free-running counter 0..SCAN_DIV, unaffected by run and clear.
  - At terminal count: counter → 0 and digit index advances 0→1→2→3→0.
  - an and seg are registered from the index and current bcd_out, updating on the same edge. Display lags bcd_out by at most 1 cycle.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 1111111 (blank, defensive)
- No leading-zero blanking. No decimal point.

Decomposition:
- Shared package seg7_pkg:
  - digit width constant (4) and digit-count constant (4)
  - the ten active-low segment pattern constants plus SEG_BLANK
  - a pure decode function (bcd → seg)
- One natural sub-module: sync_2ff (1-bit, async active-high reset to 0), instantiated three times.
- BCD counter and scanner stay in the top; each is too small to justify its own module.

Test Plan (SCAN_DIV = 3 unless noted):
1. Reset mid-scan: assert rst asynchronously between edges → immediately bcd_out = 0000, rollover = 0, an = 1110, seg = 1000000. Release; hold tick_in = 0 for 20 cycles → bcd_out stays 0000.
2. Latency and single-count: run = 1; tick_in high for 50 cycles, then low; repeat 12 times → bcd_out = 16'h0012. First change appears exactly 2 edges after tick_in is first sampled high.
3. Carry chain: preload by ticking to 0099, then one more tick → 0100. Tick to 9999, then one more tick → bcd_out = 0000 with rollover high for exactly 1 cycle.
4. Priority: clear = 1 and a tick edge in the same cycle at count 0005 → 0000 and no increment. With run = 0, 3 ticks → count unchanged; raise run → no retroactive increments.
5. Scan: bcd_out = 16'h1234 → every 4 cycles the (an, seg) pair steps:
   - (1110, 0011001)
   - (1101, 0110000)
   - (1011, 0100100)
   - (0111, 1111001)
   - then wraps to the first.
6. Glitch robustness: tick_in pulse of 1 cycle aligned to the clock, and a tick_in that toggles twice within 2 cycles → at most one increment per synchronized rising edge. No X on any output.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-seven-segment decoder for the tick counter display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7_decode(input logic [DIGIT_W-1:0] bcd);
    case (bcd)
      4'd0:    seg7_decode = SEG_0;
      4'd1:    seg7_decode = SEG_1;
      4'd2:    seg7_decode = SEG_2;
      4'd3:    seg7_decode = SEG_3;
      4'd4:    seg7_decode = SEG_4;
      4'd5:    seg7_decode = SEG_5;
      4'd6:    seg7_decode = SEG_6;
      4'd7:    seg7_decode = SEG_7;
      4'd8:    seg7_decode = SEG_8;
      4'd9:    seg7_decode = SEG_9;
      default: seg7_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// 4-digit BCD seconds counter fed by the divided clock, with run/clear controls
// and a multiplexed active-low seven-segment display driver.
module bcd_tick_counter
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 99999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic        rollover,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam logic [19:0] SCAN_TC = 20'(SCAN_DIV);

  logic tick_s, run_s, clear_s;

  sync_2ff u_sync_tick  (.clk(clk), .rst(rst), .d(tick_in), .q(tick_s));
  sync_2ff u_sync_run   (.clk(clk), .rst(rst), .d(run),     .q(run_s));
  sync_2ff u_sync_clear (.clk(clk), .rst(rst), .d(clear),   .q(clear_s));

  logic        tick_d_q, tick_d_d;
  logic [15:0] bcd_q, bcd_d;
  logic        rollover_q, rollover_d;
  logic [19:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        tick_rise;

  // Ripple carry through the digits: carry[gi] means every lower digit is 9.
  logic [NUM_DIGITS:0]                carry;
  logic [NUM_DIGITS*DIGIT_W-1:0]      bcd_inc;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [DIGIT_W-1:0] dig;
      assign dig           = bcd_q[gi*DIGIT_W +: DIGIT_W];
      assign carry[gi+1]   = carry[gi] & (dig == 4'd9);
      assign bcd_inc[gi*DIGIT_W +: DIGIT_W] =
        !carry[gi]       ? dig :
        (dig == 4'd9)    ? 4'd0 : 4'(dig + 4'd1);
    end
  endgenerate

  always_comb begin
    tick_rise  = tick_s & ~tick_d_q;
    tick_d_d   = tick_s;
    bcd_d      = bcd_q;
    rollover_d = 1'b0;
    if (clear_s) begin
      bcd_d = 16'h0000;
    end else if (run_s && tick_rise) begin
      bcd_d      = bcd_inc;
      rollover_d = carry[NUM_DIGITS];
    end

    scan_d = scan_q + 20'd1;
    idx_d  = idx_q;
    if (scan_q == SCAN_TC) begin
      scan_d = 20'd0;
      idx_d  = idx_q + 2'd1;
    end

    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg7_decode(bcd_q[{idx_q, 2'b00} +: DIGIT_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_d_q   <= 1'b0;
      bcd_q      <= 16'h0000;
      rollover_q <= 1'b0;
      scan_q     <= 20'd0;
      idx_q      <= 2'd0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_0;
    end else begin
      tick_d_q   <= tick_d_d;
      bcd_q      <= bcd_d;
      rollover_q <= rollover_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign rollover = rollover_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Randomized and directed bench for bcd_tick_counter against an integer-count model.
module tb_bcd_tick_counter;

  localparam int SD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bcd_out;
  logic        rollover;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  bcd_tick_counter #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .clear(clear),
    .bcd_out(bcd_out), .rollover(rollover), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(digit_of(v, 3)), 4'(digit_of(v, 2)), 4'(digit_of(v, 1)), 4'(digit_of(v, 0))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: input samples at each edge travel through a 2-deep delay line, then edge-detect.
  int   cnt_m = 0;
  bit   roll_m = 0;
  int   edges_m = 0;
  bit   th [1:3];
  bit   rh [1:3];
  bit   ch [1:3];
  logic [3:0] an_m;
  logic [6:0] seg_m;

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      cnt_m = 0; roll_m = 0; edges_m = 0;
      for (int k = 1; k <= 3; k++) begin th[k] = 0; rh[k] = 0; ch[k] = 0; end
      an_m = 4'b1110; seg_m = 7'b1000000;
      started = 1;
    end else begin
      idx   = (edges_m / (SD + 1)) % 4;
      an_m  = ~(4'b0001 << idx);
      seg_m = seg_of(digit_of(cnt_m, idx));
      if (ch[2]) begin
        cnt_m = 0; roll_m = 0;
      end else if (rh[2] && th[2] && !th[3]) begin
        roll_m = (cnt_m == 9999);
        cnt_m  = (cnt_m + 1) % 10000;
      end else begin
        roll_m = 0;
      end
      th[3] = th[2]; th[2] = th[1]; th[1] = tick_in;
      rh[3] = rh[2]; rh[2] = rh[1]; rh[1] = run;
      ch[3] = ch[2]; ch[2] = ch[1]; ch[1] = clear;
      edges_m++;
    end
    #1;
    if (started) begin
      chk("bcd_model", 32'(bcd_out), 32'(to_bcd(cnt_m)));
      chk("roll_model", 32'(rollover), 32'(roll_m));
      chk("an_model", 32'(an), 32'(an_m));
      chk("seg_model", 32'(seg), 32'(seg_m));
    end
  end

  task automatic do_tick(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick(2, 2);
  endtask

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] scan_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    int rc;
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Get a nonzero count and a non-zero digit index, then reset between edges.
    run = 1'b1;
    repeat (4) @(negedge clk);
    tick_n(3);
    t = 0;
    while (an !== 4'b1101 && t < 100) begin @(negedge clk); t++; end
    chk("wait_an_1101", 32'(t < 100), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'h0000);
    chk("rst_roll", 32'(rollover), 32'd0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_bcd", 32'(bcd_out), 32'h0000);

    // Latency: tick_in sampled high at edge N shows up in bcd_out at edge N+2.
    run = 1'b1;
    repeat (4) @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("lat_n1", 32'(bcd_out), 32'h0000);
    @(posedge clk); #1;
    chk("lat_n2", 32'(bcd_out), 32'h0001);
    @(negedge clk);
    repeat (47) @(negedge clk);
    tick_in = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 11; i++) do_tick(50, 50);
    chk("twelve", 32'(bcd_out), 32'h0012);

    // Carry chain.
    clear = 1'b1; repeat (4) @(negedge clk); clear = 1'b0; repeat (4) @(negedge clk);
    tick_n(99);
    chk("c_0099", 32'(bcd_out), 32'h0099);
    tick_n(1);
    chk("c_0100", 32'(bcd_out), 32'h0100);
    tick_n(9899);
    chk("c_9999", 32'(bcd_out), 32'h9999);
    tick_in = 1'b1;
    rc = 0;
    repeat (10) begin @(posedge clk); #1; if (rollover === 1'b1) rc++; end
    @(negedge clk); tick_in = 1'b0; repeat (3) @(negedge clk);
    chk("wrap_bcd", 32'(bcd_out), 32'h0000);
    chk("wrap_roll_cycles", 32'(rc), 32'd1);

    // Clear beats a simultaneous tick.
    tick_n(5);
    chk("p_0005", 32'(bcd_out), 32'h0005);
    clear = 1'b1; tick_in = 1'b1;
    repeat (6) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    chk("p_clear", 32'(bcd_out), 32'h0000);
    tick_n(3);
    run = 1'b0; repeat (4) @(negedge clk);
    tick_n(3);
    chk("p_run0", 32'(bcd_out), 32'h0003);
    run = 1'b1; repeat (8) @(negedge clk);
    chk("p_run1", 32'(bcd_out), 32'h0003);

    // Scan sequence with bcd_out = 1234.
    tick_n(1231);
    chk("s_1234", 32'(bcd_out), 32'h1234);
    t = 0;
    while (an === 4'b1110 && t < 100) begin @(posedge clk); #1; t++; end
    while (an !== 4'b1110 && t < 100) begin @(posedge clk); #1; t++; end
    chk("wait_scan", 32'(t < 100), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("scan_an", 32'(an), 32'(scan_an[(i / 4) % 4]));
      chk("scan_seg", 32'(seg), 32'(scan_seg[(i / 4) % 4]));
      @(posedge clk); #1;
    end

    // Glitches: one-cycle pulse, then 1-0-1 toggling across consecutive edges.
    @(negedge clk);
    do_tick(1, 4);
    chk("g_pulse", 32'(bcd_out), 32'h1235);
    tick_in = 1'b1; @(negedge clk); tick_in = 1'b0; @(negedge clk);
    tick_in = 1'b1; @(negedge clk); tick_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("g_toggle", 32'(bcd_out), 32'h1237);

    // Randomized traffic, including mid-cycle glitches the clock never samples.
    for (int i = 0; i < 3000; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      run     = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        #2 tick_in = ~tick_in;
        #2 tick_in = ~tick_in;
      end
      @(negedge clk);
    end
    clear = 1'b0; tick_in = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
